// File: rtl/bus_master_port_if.sv
// Bus master port signal bundle: command side, arbiter/serial bus side, status.
// master = the port itself; slave = controller, arbiter and slave model.
interface bus_master_port_if;
  logic        enable;
  logic        read_en;
  logic [2:0]  burst_mode;
  logic [7:0]  data_in;
  logic [13:0] addr_in;
  logic        m_request;
  logic        m_grant;
  logic        m_out;
  logic        m_out_valid;
  logic        m_in;
  logic        m_in_valid;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  enable, read_en, burst_mode, data_in, addr_in,
    input  m_grant, m_in, m_in_valid,
    output m_request, m_out, m_out_valid,
    output data_out, data_out_valid, busy, done, error
  );

  modport slave (
    output enable, read_en, burst_mode, data_in, addr_in,
    output m_grant, m_in, m_in_valid,
    input  m_request, m_out, m_out_valid,
    input  data_out, data_out_valid, busy, done, error
  );
endinterface

// File: rtl/bus_master_port.sv
// Serial bus master: request/grant, 14-bit address + rw + 8-bit data frames,
// bursts, split recovery, read timeout. Ports: clk, reset, bus (master).
module bus_master_port #(
  parameter int RD_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  bus_master_port_if.master  bus
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, REQ, ADDR, CTRL, WDATA,
    RWAIT, RDATA, SPLIT, FINISH
  } state_t;

  state_t        state_q;
  logic          rw_q;
  logic [2:0]    beats_q;
  logic [7:0]    wdata_q;
  logic [13:0]   addr_q;
  logic [3:0]    bit_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    shift_q;

  logic          req_q;
  logic          out_q;
  logic          outv_q;
  logic [7:0]    dout_q;
  logic          doutv_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [3:0]    bit_nxt_d;
  logic [13:0]   addr_nxt_d;
  logic [7:0]    shift_d;
  logic          last_d;

  assign bit_nxt_d  = bit_q + 4'd1;
  assign addr_nxt_d = addr_q + 14'd1;
  // LSB arrives first, so new bits enter at the top and drift down.
  assign shift_d    = {bus.m_in, shift_q[7:1]};
  assign last_d     = (beats_q == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      beats_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      bit_q   <= '0;
      tmo_q   <= '0;
      shift_q <= '0;
      req_q   <= 1'b0;
      out_q   <= 1'b0;
      outv_q  <= 1'b0;
      dout_q  <= '0;
      doutv_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      doutv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.enable) begin
            rw_q    <= bus.read_en;
            beats_q <= bus.burst_mode;
            wdata_q <= bus.data_in;
            addr_q  <= bus.addr_in;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ, SPLIT: begin
          // A split restarts the current beat from address bit 0.
          if (bus.m_grant) begin
            state_q <= ADDR;
            bit_q   <= '0;
            out_q   <= addr_q[0];
            outv_q  <= 1'b1;
          end
        end
        ADDR: begin
          if (!bus.m_grant) begin
            state_q <= SPLIT;
            out_q   <= 1'b0;
            outv_q  <= 1'b0;
          end else if (bit_q == 4'd13) begin
            state_q <= CTRL;
            out_q   <= rw_q;
          end else begin
            bit_q <= bit_nxt_d;
            out_q <= addr_q[bit_nxt_d];
          end
        end
        CTRL: begin
          if (!bus.m_grant) begin
            state_q <= SPLIT;
            out_q   <= 1'b0;
            outv_q  <= 1'b0;
          end else if (rw_q) begin
            state_q <= RWAIT;
            out_q   <= 1'b0;
            outv_q  <= 1'b0;
            tmo_q   <= '0;
          end else begin
            state_q <= WDATA;
            bit_q   <= '0;
            out_q   <= wdata_q[0];
          end
        end
        WDATA: begin
          if (!bus.m_grant) begin
            state_q <= SPLIT;
            out_q   <= 1'b0;
            outv_q  <= 1'b0;
          end else if (bit_q != 4'd7) begin
            bit_q <= bit_nxt_d;
            out_q <= wdata_q[bit_nxt_d[2:0]];
          end else if (last_d) begin
            state_q <= FINISH;
            out_q   <= 1'b0;
            outv_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            // Next beat keeps the grant; valid stays high.
            state_q <= ADDR;
            beats_q <= beats_q - 3'd1;
            addr_q  <= addr_nxt_d;
            wdata_q <= wdata_q + 8'd1;
            bit_q   <= '0;
            out_q   <= addr_nxt_d[0];
          end
        end
        RWAIT: begin
          // Grant is not checked: the slave owns the return path.
          if (bus.m_in_valid) begin
            state_q <= RDATA;
            shift_q <= shift_d;
            bit_q   <= 4'd1;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= FINISH;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RDATA: begin
          if (bus.m_in_valid) begin
            shift_q <= shift_d;
            if (bit_q != 4'd7) begin
              bit_q <= bit_nxt_d;
            end else begin
              dout_q  <= shift_d;
              doutv_q <= 1'b1;
              if (last_d) begin
                state_q <= FINISH;
                req_q   <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ADDR;
                beats_q <= beats_q - 3'd1;
                addr_q  <= addr_nxt_d;
                bit_q   <= '0;
                out_q   <= addr_nxt_d[0];
                outv_q  <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
          outv_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_request      = req_q;
  assign bus.m_out          = out_q;
  assign bus.m_out_valid    = outv_q;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = doutv_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.error          = err_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed cases plus random transfers checked
// against a frame-level model of the serial stream and read bytes.
module tb_bus_master_port;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_master_port_if bus ();
  bus_master_port #(.RD_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  bit         obs_bits[$];
  int         runs[$];
  logic [7:0] dov[$];
  int         run_len = 0;
  int         done_n = 0;
  int         err_n = 0;
  int         req_rise = 0;
  int         bad_pulse = 0;
  logic       req_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.m_out_valid === 1'b1) begin
      obs_bits.push_back(bus.m_out);
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len <= 0;
    end
    if (bus.done === 1'b1) done_n <= done_n + 1;
    if (bus.error === 1'b1) err_n <= err_n + 1;
    if ((bus.done === 1'b1 || bus.error === 1'b1) && bus.m_request !== 1'b0)
      bad_pulse <= bad_pulse + 1;
    if (bus.done === 1'b1 && bus.error === 1'b1)
      bad_pulse <= bad_pulse + 1;
    if (bus.data_out_valid === 1'b1) dov.push_back(bus.data_out);
    if (bus.m_request === 1'b1 && req_prev !== 1'b1)
      req_rise <= req_rise + 1;
    req_prev <= bus.m_request;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit         exp_bits[$];
  logic [7:0] exp_rd[$];
  int m_bits, m_runs, m_done, m_err, m_req, m_dov;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {bus.m_request, bus.m_out, bus.m_out_valid, bus.busy,
            bus.done, bus.error, bus.data_out_valid, bus.data_out};
  endfunction

  function automatic int run_at(int i);
    return (runs.size() > i) ? runs[i] : -1;
  endfunction

  task automatic mark();
    m_bits = obs_bits.size();
    m_runs = runs.size();
    m_done = done_n;
    m_err  = err_n;
    m_req  = req_rise;
    m_dov  = dov.size();
    exp_bits.delete();
    exp_rd.delete();
  endtask

  task automatic model_beat(int a, bit rw, int d);
    for (int i = 0; i < 14; i++) exp_bits.push_back(bit'((a >> i) & 1));
    exp_bits.push_back(rw);
    if (!rw)
      for (int i = 0; i < 8; i++) exp_bits.push_back(bit'((d >> i) & 1));
  endtask

  task automatic model_xfer(int a, bit rw, int d, int burst);
    for (int k = 0; k <= burst; k++)
      model_beat((a + k) % 16384, rw, (d + k) % 256);
  endtask

  task automatic chk_stream(string tag);
    int bad = 0;
    int n = obs_bits.size() - m_bits;
    chk({tag, "_len"}, n, exp_bits.size());
    for (int i = 0; i < n && i < exp_bits.size(); i++)
      if (obs_bits[m_bits + i] !== exp_bits[i]) bad++;
    chk({tag, "_bits"}, bad, 0);
  endtask

  task automatic chk_dov(string tag);
    int bad = 0;
    int n = dov.size() - m_dov;
    chk({tag, "_nrd"}, n, exp_rd.size());
    for (int i = 0; i < n && i < exp_rd.size(); i++)
      if (dov[m_dov + i] !== exp_rd[i]) bad++;
    chk({tag, "_rdata"}, bad, 0);
  endtask

  task automatic chk_end(string tag, int nd, int ne);
    chk({tag, "_done"}, done_n - m_done, nd);
    chk({tag, "_err"}, err_n - m_err, ne);
    chk({tag, "_reqs"}, req_rise - m_req, 1);
  endtask

  task automatic start(string tag, bit rd, int burst, int d, int a);
    bus.enable     = 1'b1;
    bus.read_en    = rd;
    bus.burst_mode = 3'(burst);
    bus.data_in    = 8'(d);
    bus.addr_in    = 14'(a);
    tick();
    bus.enable     = 1'b0;
    bus.read_en    = ~rd;
    bus.burst_mode = 3'($urandom);
    bus.data_in    = 8'($urandom);
    bus.addr_in    = 14'($urandom);
    chk({tag, "_req_next"}, bus.m_request, 1);
    chk({tag, "_busy_next"}, bus.busy, 1);
  endtask

  task automatic grant_after(string tag, int n);
    int bad = 0;
    repeat (n) begin
      tick();
      if (bus.m_request !== 1'b1 || bus.m_out_valid !== 1'b0) bad++;
    end
    chk({tag, "_req_hold"}, bad, 0);
    bus.m_grant = 1'b1;
  endtask

  task automatic wait_idle(string tag, int budget);
    int n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, bus.busy, 0);
    bus.m_grant = 1'b0;
  endtask

  task automatic wait_rwait(string tag);
    int n = 0;
    while (bus.m_out_valid !== 1'b1 && n < 60) begin tick(); n++; end
    while (bus.m_out_valid === 1'b1 && n < 60) begin tick(); n++; end
    chk({tag, "_rwait"}, 32'(n < 60), 1);
  endtask

  task automatic serve_read(string tag, logic [7:0] v, int pre,
                            logic [6:0] smask);
    wait_rwait(tag);
    bus.enable = 1'b1;
    repeat (pre) begin
      bus.m_in = 1'($urandom);
      tick();
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.m_in_valid = 1'b1;
      bus.m_in       = v[i];
      tick();
      bus.m_in_valid = 1'b0;
      bus.m_in       = 1'($urandom);
      if (i < 7 && smask[i]) begin
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
      end
    end
    chk({tag, "_dov_pulse"}, bus.data_out_valid, 1);
    chk({tag, "_dout"}, bus.data_out, v);
  endtask

  initial begin
    int a, d, bu, n, nv, bad, pre;
    bit rd;
    logic [7:0] v;
    bus.enable = 0; bus.read_en = 0; bus.burst_mode = 0;
    bus.data_in = 0; bus.addr_in = 0; bus.m_grant = 0;
    bus.m_in = 0; bus.m_in_valid = 0;

    reset = 1'b1;
    tick(); tick();
    chk("rst_outs", 32'(outs()), 0);
    reset = 1'b0;
    tick();
    chk("rst_idle", 32'(outs()), 0);

    // single-beat write
    mark();
    model_xfer(5012, 1'b0, 78, 0);
    start("wr", 1'b0, 0, 78, 5012);
    grant_after("wr", 2);
    wait_idle("wr", 100);
    chk_stream("wr");
    chk("wr_runs", runs.size() - m_runs, 1);
    chk("wr_run23", run_at(m_runs), 23);
    chk_end("wr", 1, 0);

    // single-beat read with stalls
    mark();
    model_xfer(1001, 1'b1, 0, 0);
    exp_rd.push_back(8'hA5);
    start("rd", 1'b1, 0, 8'h33, 1001);
    grant_after("rd", 1);
    serve_read("rd", 8'hA5, 0, 7'b0100101);
    wait_idle("rd", 20);
    chk_stream("rd");
    chk_dov("rd");
    chk("rd_run15", run_at(m_runs), 15);
    chk_end("rd", 1, 0);

    // burst write crossing the 14-bit address wrap
    mark();
    model_xfer(16382, 1'b0, 102, 2);
    start("bw", 1'b0, 2, 102, 16382);
    grant_after("bw", 1);
    wait_idle("bw", 200);
    chk_stream("bw");
    chk("bw_runs", runs.size() - m_runs, 1);
    chk("bw_run69", run_at(m_runs), 69);
    chk_end("bw", 1, 0);

    // split at address bit 10
    a = int'($urandom_range(16383, 0));
    d = int'($urandom_range(255, 0));
    mark();
    for (int i = 0; i < 11; i++) exp_bits.push_back(bit'((a >> i) & 1));
    model_xfer(a, 1'b0, d, 0);
    start("sp", 1'b0, 0, d, a);
    grant_after("sp", 0);
    n = 0; nv = 0;
    while (nv < 11 && n < 40) begin
      tick(); n++;
      if (bus.m_out_valid === 1'b1) nv++;
    end
    bus.m_grant = 1'b0;
    bad = 0;
    repeat (5) begin
      tick();
      if (bus.m_out_valid !== 1'b0 || bus.m_request !== 1'b1 ||
          bus.busy !== 1'b1) bad++;
    end
    chk("sp_hold", bad, 0);
    bus.m_grant = 1'b1;
    wait_idle("sp", 80);
    chk_stream("sp");
    chk("sp_runs", runs.size() - m_runs, 2);
    chk("sp_part", run_at(m_runs), 11);
    chk("sp_resume23", run_at(m_runs + 1), 23);
    chk_end("sp", 1, 0);

    // read timeout
    mark();
    start("tmo", 1'b1, 0, 0, a);
    grant_after("tmo", 0);
    wait_rwait("tmo");
    n = 0;
    while (bus.error !== 1'b1 && n < 40) begin tick(); n++; end
    chk("tmo_cycles", n, 15);
    chk("tmo_req", bus.m_request, 0);
    chk("tmo_done", bus.done, 0);
    tick();
    chk("tmo_pulse", bus.error, 0);
    chk("tmo_busy", bus.busy, 0);
    bus.m_grant = 1'b0;
    chk_end("tmo", 0, 1);

    // reset at write data bit 3, then a fresh write
    start("rs", 1'b0, 0, d, a);
    grant_after("rs", 0);
    n = 0; nv = 0;
    while (nv < 19 && n < 60) begin
      tick(); n++;
      if (bus.m_out_valid === 1'b1) nv++;
    end
    reset = 1'b1;
    tick();
    chk("rs_outs", 32'(outs()), 0);
    reset = 1'b0;
    bus.m_grant = 1'b0;
    mark();
    repeat (3) tick();
    chk("rs_nopulse", (done_n - m_done) + (err_n - m_err), 0);
    chk("rs_quiet", 32'(outs()), 0);
    mark();
    model_xfer(a ^ 14'h2AA, 1'b0, d ^ 8'h5C, 0);
    start("rs2", 1'b0, 0, d ^ 8'h5C, a ^ 14'h2AA);
    grant_after("rs2", 1);
    wait_idle("rs2", 100);
    chk_stream("rs2");
    chk_end("rs2", 1, 0);

    // random transfers
    for (int t = 0; t < 12; t++) begin
      rd = 1'($urandom);
      bu = int'($urandom_range(7, 0));
      a  = int'($urandom_range(16383, 0));
      d  = int'($urandom_range(255, 0));
      mark();
      model_xfer(a, rd, d, bu);
      start("rnd", rd, bu, d, a);
      grant_after("rnd", int'($urandom_range(3, 0)));
      if (rd) begin
        for (int k = 0; k <= bu; k++) begin
          v   = 8'($urandom);
          pre = int'($urandom_range(4, 0));
          exp_rd.push_back(v);
          serve_read("rnd", v, pre, 7'($urandom));
        end
      end
      wait_idle("rnd", 400);
      chk_stream("rnd");
      chk_dov("rnd");
      chk_end("rnd", 1, 0);
      tick();
    end

    chk("pulse_req_low", bad_pulse, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_master_port.md
BUS_MASTER_PORT -- requirements
Module: bus_master_port

Interface
REQ-001 Parameters: RD_TIMEOUT, default 15, maximum idle cycles allowed in read-wait before the transfer aborts.
REQ-002 Port: clk  in  1  sole clock; all logic on the rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: enable  in  1  command strobe from the test controller; sampled only in IDLE.
REQ-005 Port: read_en  in  1  1 = read, 0 = write; captured with enable.
REQ-006 Port: burst_mode  in  3  extra beats; beat count = burst_mode+1 (1..8).
REQ-007 Port: data_in  in  8  write data for beat 0.
REQ-008 Port: addr_in  in  14  start address; [13:12] = slave select, [11:0] = offset.
REQ-009 Port: m_request  out  1  bus request to the arbiter.
REQ-010 Port: m_grant  in  1  bus grant from the arbiter.
REQ-011 Port: m_out  out  1  serial bus bit.
REQ-012 Port: m_out_valid  out  1  m_out qualifier.
REQ-013 Port: m_in  in  1  serial read bit from the slave.
REQ-014 Port: m_in_valid  in  1  m_in qualifier.
REQ-015 Port: data_out  out  8  assembled read byte.
REQ-016 Port: data_out_valid  out  1  one-cycle pulse per read beat.
REQ-017 Port: busy  out  1  high in every state except IDLE.
REQ-018 Port: done  out  1  one-cycle pulse at normal completion.
REQ-019 Port: error  out  1  one-cycle pulse on read timeout.

Function
REQ-020 Outputs SHALL be registered; states are IDLE, REQ, ADDR, CTRL, WDATA, RWAIT, RDATA, SPLIT, FINISH.
REQ-021 IDLE SHALL move to REQ when enable=1, capturing read_en, burst_mode, data_in and addr_in; m_request=1 from the next cycle.
REQ-022 enable SHALL be ignored in every state other than IDLE.
REQ-023 REQ SHALL move to ADDR on the edge where m_grant=1; m_request SHALL stay high until FINISH.
REQ-024 ADDR SHALL drive 14 cycles: m_out = current address bit i, LSB first, i = 0..13, with m_out_valid=1.
REQ-025 CTRL SHALL drive one cycle: m_out = rw bit (1 = read), m_out_valid=1.
REQ-026 WDATA SHALL drive 8 cycles LSB first; beat k data = (captured data + k) mod 256.
REQ-027 A single-beat write SHALL hold m_out_valid high for exactly 23 consecutive cycles.
REQ-028 RWAIT SHALL hold m_out_valid=0 and move to RDATA on the first cycle with m_in_valid=1; that bit is read bit 0.
REQ-029 RDATA SHALL shift in m_in LSB first on each m_in_valid=1 cycle and ignore cycles with m_in_valid=0.
REQ-030 On the 8th read bit, data_out SHALL be updated and data_out_valid SHALL pulse in the following cycle.
REQ-031 After each beat, if beats remain, the address SHALL increment by 1 (14-bit wrap: 16383 -> 0) and the FSM SHALL re-enter ADDR without a new grant.
REQ-032 After the last beat, FINISH SHALL run for one cycle: m_request=0, done=1; the FSM then returns to IDLE.
REQ-033 If m_grant=0 in ADDR, CTRL or WDATA, the FSM SHALL enter SPLIT, set m_out_valid=0 and keep m_request=1.
REQ-034 When m_grant returns, SPLIT SHALL restart the current beat from address bit 0; completed beats SHALL NOT be resent.
REQ-035 In RWAIT, RD_TIMEOUT consecutive cycles without m_in_valid SHALL cause error=1 and m_request=0 for one cycle, then IDLE, with no done pulse.
REQ-036 Grant loss in RWAIT or RDATA SHALL be ignored; the slave owns the return path.

Reset
REQ-037 With reset=1 at an edge, the next cycle SHALL show: state IDLE; m_request, m_out, m_out_valid, busy, done, error, data_out_valid = 0; data_out = 8'd0; all counters and captured fields = 0.
REQ-038 Reset SHALL take priority over every transition, including mid-frame; no done or error pulse SHALL follow.

Verification
REQ-039 Write: addr_in=5012, data_in=78, burst_mode=0, read_en=0, grant 2 cycles after request -> 14 address bits of 5012 LSB first, rw=0, then 8 bits of 78; done pulses once.
REQ-040 Read: addr_in=1001, read_en=1; slave returns 0xA5 with 3 stall cycles interleaved -> data_out=0xA5, one data_out_valid pulse, then done.
REQ-041 Burst write: addr_in=16382, data_in=102, burst_mode=2 -> 3 beats at addresses 16382, 16383, 0 with data 102, 103, 104; single request period.
REQ-042 Split: m_grant dropped at address bit 10 for 5 cycles -> m_out_valid low throughout; the beat resends from bit 0; total valid cycles after resume = 23.
REQ-043 Timeout and reset: read with no m_in_valid -> error after 15 cycles and m_request falls; a separate reset asserted at WDATA bit 3 -> all outputs 0 next cycle and enable accepted again.
